// File: rtl/axi_bridge_ip_rx.sv
// axi_bridge_ip_rx: egress path of the IP bridge.
// Packs IF_W-wide Client-IF segments (sop/eop framed) into DATA_W-wide
// AXI-Stream beats, buffers complete beats in a small FWFT FIFO and
// exposes telemetry counters and one-cycle error pulses.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cl_rx_*                 Client-IF segment input (valid/ready)
//   m_axis_*                AXI-Stream beat output toward the IP
//   bridge_enable, strict_seq_en, strict_keep_en, drop_on_midreset  CSR controls
//   stat_rx_*               telemetry counters (wrap modulo 2^32)
//   ev_err_*                registered one-cycle error pulses
module axi_bridge_ip_rx #(
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned IF_W       = 64,
    parameter int unsigned TUSER_W    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IF_W-1:0]      cl_rx_data,
    input  logic [IF_W/8-1:0]    cl_rx_keep,
    input  logic [TUSER_W-1:0]   cl_rx_user,
    input  logic                 cl_rx_valid,
    input  logic                 cl_rx_sop,
    input  logic                 cl_rx_eop,
    output logic                 cl_rx_ready,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic [DATA_W/8-1:0]  m_axis_tkeep,
    output logic [TUSER_W-1:0]   m_axis_tuser,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    input  logic                 bridge_enable,
    input  logic                 strict_seq_en,
    input  logic                 strict_keep_en,
    input  logic                 drop_on_midreset,
    output logic [31:0]          stat_rx_frames,
    output logic [31:0]          stat_rx_bytes,
    output logic [15:0]          stat_rx_fifo_level,
    output logic [31:0]          stat_rx_stall_cycles,
    output logic                 ev_err_seq,
    output logic                 ev_err_keep_illegal,
    output logic                 ev_err_midreset_drop
);

    localparam int unsigned SEGS   = DATA_W / IF_W;
    localparam int unsigned SEG_B  = IF_W / 8;
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned IDX_W  = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [KEEP_W-1:0]  keep;
        logic [TUSER_W-1:0] user;
        logic               last;
    } beat_t;

    typedef enum logic [0:0] {IDLE, IN_PKT} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   seg_idx;
    logic [DATA_W-1:0]  acc_data;
    logic [KEEP_W-1:0]  acc_keep;
    logic [TUSER_W-1:0] frame_user;

    beat_t              mem [FIFO_DEPTH];
    beat_t              head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               en_q;

    logic  seg_fire, pack_c, capture_c, err_seq_c, err_keep_c;
    logic  close_c, pop_c, flush_c, fifo_empty, keep_contig;
    beat_t beat_c;

    assign fifo_empty  = (level == '0);
    assign cl_rx_ready = bridge_enable && (level < LVL_W'(FIFO_DEPTH));
    assign seg_fire    = cl_rx_valid && cl_rx_ready;
    assign pop_c       = !fifo_empty && m_axis_tready;

    // Mid-frame flush on a registered falling edge of bridge_enable.
    assign flush_c = drop_on_midreset && en_q && !bridge_enable &&
                     ((state == IN_PKT) || (seg_idx != '0) || !fifo_empty);

    // Framing FSM: decides whether the accepted segment is packed.
    always_comb begin
        state_n   = state;
        pack_c    = 1'b0;
        capture_c = 1'b0;
        err_seq_c = 1'b0;
        if (seg_fire) begin
            case (state)
                IDLE: begin
                    if (cl_rx_sop || !strict_seq_en) begin
                        pack_c    = 1'b1;
                        capture_c = 1'b1;
                        state_n   = cl_rx_eop ? IDLE : IN_PKT;
                    end else begin
                        err_seq_c = 1'b1;
                    end
                end
                IN_PKT: begin
                    pack_c    = 1'b1;
                    err_seq_c = cl_rx_sop && strict_seq_en;
                    if (cl_rx_eop) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_c) state <= IDLE;
        else                  state <= state_n;
    end

    // Keep legality: full on non-eop, LSB-contiguous and non-zero on eop.
    assign keep_contig = ((cl_rx_keep & (cl_rx_keep + SEG_B'(1))) == '0);
    assign err_keep_c  = pack_c && strict_keep_en &&
                         (cl_rx_eop ? ((cl_rx_keep == '0) || !keep_contig)
                                    : !(&cl_rx_keep));

    // Beat under construction with the current segment merged in.
    always_comb begin
        beat_c.data = acc_data;
        beat_c.keep = acc_keep;
        for (int unsigned s = 0; s < SEGS; s++) begin
            if (seg_idx == IDX_W'(s)) begin
                beat_c.data[s*IF_W +: IF_W]   = cl_rx_data;
                beat_c.keep[s*SEG_B +: SEG_B] = cl_rx_keep;
            end
        end
        beat_c.user = capture_c ? cl_rx_user : frame_user;
        beat_c.last = cl_rx_eop;
    end

    assign close_c = pack_c && ((seg_idx == IDX_W'(SEGS - 1)) || cl_rx_eop);

    // Packer accumulator.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_c) begin
            seg_idx    <= '0;
            acc_data   <= '0;
            acc_keep   <= '0;
            frame_user <= '0;
        end else if (pack_c) begin
            if (capture_c) frame_user <= cl_rx_user;
            if (close_c) begin
                seg_idx  <= '0;
                acc_data <= '0;
                acc_keep <= '0;
            end else begin
                seg_idx  <= seg_idx + IDX_W'(1);
                acc_data <= beat_c.data;
                acc_keep <= beat_c.keep;
            end
        end
    end

    // FIFO storage; ready guarantees room whenever a beat closes.
    always_ff @(posedge clk_i) begin
        if (close_c) mem[wr_ptr] <= beat_c;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (close_c)
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop_c)
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({close_c, pop_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // FWFT head; payload forced to zero while empty.
    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : head.data;
    assign m_axis_tkeep  = fifo_empty ? '0 : head.keep;
    assign m_axis_tuser  = fifo_empty ? '0 : head.user;
    assign m_axis_tlast  = fifo_empty ? 1'b0 : head.last;

    // Telemetry and event pulses; counters survive a mid-frame flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_rx_frames       <= '0;
            stat_rx_bytes        <= '0;
            stat_rx_stall_cycles <= '0;
            stat_rx_fifo_level   <= '0;
            ev_err_seq           <= 1'b0;
            ev_err_keep_illegal  <= 1'b0;
            ev_err_midreset_drop <= 1'b0;
            en_q                 <= 1'b0;
        end else begin
            if (pop_c && head.last) stat_rx_frames <= stat_rx_frames + 32'd1;
            if (pack_c) stat_rx_bytes <= stat_rx_bytes + 32'($countones(cl_rx_keep));
            if (m_axis_tvalid && !m_axis_tready)
                stat_rx_stall_cycles <= stat_rx_stall_cycles + 32'd1;
            stat_rx_fifo_level   <= 16'(level);
            ev_err_seq           <= err_seq_c;
            ev_err_keep_illegal  <= err_keep_c;
            ev_err_midreset_drop <= flush_c;
            en_q                 <= bridge_enable;
        end
    end

endmodule

// File: tb/tb_axi_bridge_ip_rx.sv
// Directed self-checking bench for axi_bridge_ip_rx (default parameters).
module tb_axi_bridge_ip_rx;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [63:0]  cl_rx_data;
    logic [7:0]   cl_rx_keep;
    logic [15:0]  cl_rx_user;
    logic         cl_rx_valid, cl_rx_sop, cl_rx_eop;
    logic         cl_rx_ready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [15:0]  m_axis_tuser;
    logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic         bridge_enable, strict_seq_en, strict_keep_en, drop_on_midreset;
    logic [31:0]  stat_rx_frames, stat_rx_bytes, stat_rx_stall_cycles;
    logic [15:0]  stat_rx_fifo_level;
    logic         ev_err_seq, ev_err_keep_illegal, ev_err_midreset_drop;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    axi_bridge_ip_rx dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cl_rx_data(cl_rx_data), .cl_rx_keep(cl_rx_keep), .cl_rx_user(cl_rx_user),
        .cl_rx_valid(cl_rx_valid), .cl_rx_sop(cl_rx_sop), .cl_rx_eop(cl_rx_eop),
        .cl_rx_ready(cl_rx_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .bridge_enable(bridge_enable), .strict_seq_en(strict_seq_en),
        .strict_keep_en(strict_keep_en), .drop_on_midreset(drop_on_midreset),
        .stat_rx_frames(stat_rx_frames), .stat_rx_bytes(stat_rx_bytes),
        .stat_rx_fifo_level(stat_rx_fifo_level), .stat_rx_stall_cycles(stat_rx_stall_cycles),
        .ev_err_seq(ev_err_seq), .ev_err_keep_illegal(ev_err_keep_illegal),
        .ev_err_midreset_drop(ev_err_midreset_drop)
    );

    function automatic logic [63:0] pat(input int t, input int i);
        return {16'hC0DE, 16'(t), 16'(i), 16'hBEEF};
    endfunction

    function automatic logic [255:0] full_beat(input int t);
        return {pat(t, 3), pat(t, 2), pat(t, 1), pat(t, 0)};
    endfunction

    // Present one segment and wait (bounded) until it is accepted.
    task automatic push_seg(input logic [63:0] d, input logic [7:0] k,
                            input logic [15:0] u, input logic s, input logic e);
        int budget = 200;
        @(negedge clk_i);
        cl_rx_data = d; cl_rx_keep = k; cl_rx_user = u;
        cl_rx_sop = s; cl_rx_eop = e; cl_rx_valid = 1'b1;
        while (!cl_rx_ready && budget > 0) begin
            @(negedge clk_i);
            budget--;
        end
        if (budget == 0) begin
            total++; bad++;
            $display("FAIL push_timeout got ready=%0b exp ready=1", cl_rx_ready);
        end
        @(posedge clk_i);
        #1;
        cl_rx_valid = 1'b0; cl_rx_sop = 1'b0; cl_rx_eop = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; bridge_enable = 1'b0; m_axis_tready = 1'b0;
        strict_seq_en = 1'b0; strict_keep_en = 1'b0; drop_on_midreset = 1'b0;
        cl_rx_valid = 1'b0; cl_rx_sop = 1'b0; cl_rx_eop = 1'b0;
        cl_rx_data = '0; cl_rx_keep = '0; cl_rx_user = '0;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%0b exp=0", m_axis_tvalid); end
        total++; if (cl_rx_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", cl_rx_ready); end
        total++; if ({stat_rx_frames, stat_rx_bytes, stat_rx_stall_cycles, stat_rx_fifo_level} !== 112'd0) begin
            bad++; $display("FAIL rst_stats got=%h exp=0", {stat_rx_frames, stat_rx_bytes, stat_rx_stall_cycles, stat_rx_fifo_level}); end
        total++; if ({ev_err_seq, ev_err_keep_illegal, ev_err_midreset_drop} !== 3'b000) begin
            bad++; $display("FAIL rst_events got=%b exp=000", {ev_err_seq, ev_err_keep_illegal, ev_err_midreset_drop}); end
        @(negedge clk_i);
        rst_i = 1'b0; bridge_enable = 1'b1; m_axis_tready = 1'b1;
    endtask

    task automatic test_full_beat;
        for (int i = 0; i < 4; i++)
            push_seg(pat(1, i), 8'hFF, 16'h1234, i == 0, i == 3);
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL t1_tvalid got=%0b exp=1", m_axis_tvalid); end
        total++; if (m_axis_tdata !== full_beat(1)) begin bad++; $display("FAIL t1_tdata got=%h exp=%h", m_axis_tdata, full_beat(1)); end
        total++; if (m_axis_tkeep !== 32'hFFFFFFFF) begin bad++; $display("FAIL t1_tkeep got=%h exp=ffffffff", m_axis_tkeep); end
        total++; if (m_axis_tlast !== 1'b1) begin bad++; $display("FAIL t1_tlast got=%0b exp=1", m_axis_tlast); end
        total++; if (m_axis_tuser !== 16'h1234) begin bad++; $display("FAIL t1_tuser got=%h exp=1234", m_axis_tuser); end
        @(posedge clk_i); #1;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL t1_popped got=%0b exp=0", m_axis_tvalid); end
        total++; if (stat_rx_frames !== 32'd1) begin bad++; $display("FAIL t1_frames got=%0d exp=1", stat_rx_frames); end
        total++; if (stat_rx_bytes !== 32'd32) begin bad++; $display("FAIL t1_bytes got=%0d exp=32", stat_rx_bytes); end
    endtask

    task automatic test_partial_beat;
        for (int i = 0; i < 4; i++)
            push_seg(pat(2, i), 8'hFF, (i == 0) ? 16'hA5A5 : 16'h5A5A, i == 0, 1'b0);
        total++; if (m_axis_tkeep !== 32'hFFFFFFFF) begin bad++; $display("FAIL t2_b0_tkeep got=%h exp=ffffffff", m_axis_tkeep); end
        total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL t2_b0_tlast got=%0b exp=0", m_axis_tlast); end
        total++; if (m_axis_tuser !== 16'hA5A5) begin bad++; $display("FAIL t2_b0_tuser got=%h exp=a5a5", m_axis_tuser); end
        push_seg(pat(2, 4), 8'hFF, 16'h5A5A, 1'b0, 1'b0);
        push_seg(pat(2, 5), 8'h0F, 16'h5A5A, 1'b0, 1'b1);
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL t2_b1_tvalid got=%0b exp=1", m_axis_tvalid); end
        total++; if (m_axis_tkeep !== 32'h00000FFF) begin bad++; $display("FAIL t2_b1_tkeep got=%h exp=00000fff", m_axis_tkeep); end
        total++; if (m_axis_tlast !== 1'b1) begin bad++; $display("FAIL t2_b1_tlast got=%0b exp=1", m_axis_tlast); end
        total++; if (m_axis_tuser !== 16'hA5A5) begin bad++; $display("FAIL t2_b1_tuser got=%h exp=a5a5", m_axis_tuser); end
        total++; if (m_axis_tdata[127:0] !== {pat(2, 5), pat(2, 4)}) begin
            bad++; $display("FAIL t2_b1_tdata got=%h exp=%h", m_axis_tdata[127:0], {pat(2, 5), pat(2, 4)}); end
        @(posedge clk_i); #1;
        total++; if (stat_rx_frames !== 32'd2) begin bad++; $display("FAIL t2_frames got=%0d exp=2", stat_rx_frames); end
        total++; if (stat_rx_bytes !== 32'd76) begin bad++; $display("FAIL t2_bytes got=%0d exp=76", stat_rx_bytes); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk_i);
        m_axis_tready = 1'b0;
        for (int f = 0; f < 4; f++)
            push_seg(pat(3, f), 8'hFF, 16'(16'h0300 + f), 1'b1, 1'b1);
        total++; if (cl_rx_ready !== 1'b0) begin bad++; $display("FAIL t3_ready_full got=%0b exp=0", cl_rx_ready); end
        repeat (5) @(posedge clk_i);
        #1;
        total++; if (stat_rx_fifo_level !== 16'd4) begin bad++; $display("FAIL t3_level got=%0d exp=4", stat_rx_fifo_level); end
        total++; if (stat_rx_stall_cycles !== 32'd8) begin bad++; $display("FAIL t3_stall got=%0d exp=8", stat_rx_stall_cycles); end
        @(negedge clk_i);
        m_axis_tready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata[63:0] !== pat(3, f) || m_axis_tkeep !== 32'h000000FF) begin
                bad++; $display("FAIL t3_drain%0d got=%b/%h/%h exp=1/%h/000000ff", f, m_axis_tvalid, m_axis_tdata[63:0], m_axis_tkeep, pat(3, f)); end
            total++; if (m_axis_tuser !== 16'(16'h0300 + f)) begin bad++; $display("FAIL t3_user%0d got=%h exp=%h", f, m_axis_tuser, 16'(16'h0300 + f)); end
            @(posedge clk_i); #1;
        end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL t3_empty got=%0b exp=0", m_axis_tvalid); end
        total++; if (stat_rx_frames !== 32'd6) begin bad++; $display("FAIL t3_frames got=%0d exp=6", stat_rx_frames); end
        total++; if (stat_rx_stall_cycles !== 32'd8) begin bad++; $display("FAIL t3_stall_end got=%0d exp=8", stat_rx_stall_cycles); end
        total++; if (stat_rx_bytes !== 32'd108) begin bad++; $display("FAIL t3_bytes got=%0d exp=108", stat_rx_bytes); end
    endtask

    task automatic test_strict_seq;
        @(negedge clk_i);
        strict_seq_en = 1'b1;
        push_seg(pat(4, 9), 8'hFF, 16'hDEAD, 1'b0, 1'b0);
        total++; if (ev_err_seq !== 1'b1) begin bad++; $display("FAIL t4_seq_idle got=%0b exp=1", ev_err_seq); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL t4_no_beat got=%0b exp=0", m_axis_tvalid); end
        total++; if (stat_rx_bytes !== 32'd108) begin bad++; $display("FAIL t4_bytes_drop got=%0d exp=108", stat_rx_bytes); end
        @(posedge clk_i); #1;
        total++; if (ev_err_seq !== 1'b0) begin bad++; $display("FAIL t4_pulse_len got=%0b exp=0", ev_err_seq); end
        push_seg(pat(4, 0), 8'hFF, 16'h4444, 1'b1, 1'b0);
        push_seg(pat(4, 1), 8'hFF, 16'h9999, 1'b1, 1'b0);
        total++; if (ev_err_seq !== 1'b1) begin bad++; $display("FAIL t4_seq_inpkt got=%0b exp=1", ev_err_seq); end
        push_seg(pat(4, 2), 8'hFF, 16'h9999, 1'b0, 1'b0);
        total++; if (ev_err_seq !== 1'b0) begin bad++; $display("FAIL t4_seq_clear got=%0b exp=0", ev_err_seq); end
        push_seg(pat(4, 3), 8'hFF, 16'h9999, 1'b0, 1'b1);
        total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== full_beat(4)) begin
            bad++; $display("FAIL t4_frame got=%b/%h exp=1/%h", m_axis_tvalid, m_axis_tdata, full_beat(4)); end
        total++; if (m_axis_tuser !== 16'h4444 || m_axis_tlast !== 1'b1) begin
            bad++; $display("FAIL t4_user_last got=%h/%b exp=4444/1", m_axis_tuser, m_axis_tlast); end
        @(posedge clk_i); #1;
        total++; if (stat_rx_frames !== 32'd7 || stat_rx_bytes !== 32'd140) begin
            bad++; $display("FAIL t4_stats got=%0d/%0d exp=7/140", stat_rx_frames, stat_rx_bytes); end
        strict_seq_en = 1'b0;
    endtask

    task automatic test_strict_keep;
        @(negedge clk_i);
        strict_keep_en = 1'b1;
        push_seg(pat(5, 0), 8'hFF, 16'h5555, 1'b1, 1'b0);
        total++; if (ev_err_keep_illegal !== 1'b0) begin bad++; $display("FAIL t5_keep_ok got=%0b exp=0", ev_err_keep_illegal); end
        push_seg(pat(5, 1), 8'h7F, 16'h5555, 1'b0, 1'b0);
        total++; if (ev_err_keep_illegal !== 1'b1) begin bad++; $display("FAIL t5_keep_hole got=%0b exp=1", ev_err_keep_illegal); end
        push_seg(pat(5, 2), 8'hFF, 16'h5555, 1'b0, 1'b0);
        push_seg(pat(5, 3), 8'hFF, 16'h5555, 1'b0, 1'b1);
        total++; if (ev_err_keep_illegal !== 1'b0) begin bad++; $display("FAIL t5_keep_eop_ok got=%0b exp=0", ev_err_keep_illegal); end
        total++; if (m_axis_tkeep !== 32'hFFFF7FFF) begin bad++; $display("FAIL t5_tkeep got=%h exp=ffff7fff", m_axis_tkeep); end
        push_seg(pat(5, 4), 8'h05, 16'h5556, 1'b1, 1'b1);
        total++; if (ev_err_keep_illegal !== 1'b1) begin bad++; $display("FAIL t5_keep_eop_bad got=%0b exp=1", ev_err_keep_illegal); end
        total++; if (m_axis_tvalid !== 1'b1 || m_axis_tkeep !== 32'h00000005) begin
            bad++; $display("FAIL t5_tkeep2 got=%b/%h exp=1/00000005", m_axis_tvalid, m_axis_tkeep); end
        @(posedge clk_i); #1;
        total++; if (stat_rx_frames !== 32'd9 || stat_rx_bytes !== 32'd173) begin
            bad++; $display("FAIL t5_stats got=%0d/%0d exp=9/173", stat_rx_frames, stat_rx_bytes); end
        strict_keep_en = 1'b0;
    endtask

    task automatic test_midreset_drop;
        @(negedge clk_i);
        drop_on_midreset = 1'b1;
        m_axis_tready = 1'b0;
        push_seg(pat(6, 7), 8'hFF, 16'h6666, 1'b1, 1'b1);
        push_seg(pat(6, 8), 8'hFF, 16'h6667, 1'b1, 1'b0);
        push_seg(pat(6, 9), 8'hFF, 16'h6667, 1'b0, 1'b0);
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL t6_pre_tvalid got=%0b exp=1", m_axis_tvalid); end
        @(negedge clk_i);
        bridge_enable = 1'b0;
        @(posedge clk_i); #1;
        total++; if (ev_err_midreset_drop !== 1'b1) begin bad++; $display("FAIL t6_drop_ev got=%0b exp=1", ev_err_midreset_drop); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL t6_flushed got=%0b exp=0", m_axis_tvalid); end
        @(posedge clk_i); #1;
        total++; if (ev_err_midreset_drop !== 1'b0) begin bad++; $display("FAIL t6_drop_len got=%0b exp=0", ev_err_midreset_drop); end
        total++; if (stat_rx_bytes !== 32'd197) begin bad++; $display("FAIL t6_bytes_kept got=%0d exp=197", stat_rx_bytes); end
        @(negedge clk_i);
        bridge_enable = 1'b1; m_axis_tready = 1'b1;
        push_seg(pat(7, 0), 8'hFF, 16'h7777, 1'b1, 1'b0);
        push_seg(pat(7, 1), 8'hFF, 16'h7777, 1'b0, 1'b0);
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL t6_slot0 got=%0b exp=0", m_axis_tvalid); end
        push_seg(pat(7, 2), 8'hFF, 16'h7777, 1'b0, 1'b0);
        push_seg(pat(7, 3), 8'hFF, 16'h7777, 1'b0, 1'b1);
        total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== full_beat(7) || m_axis_tuser !== 16'h7777) begin
            bad++; $display("FAIL t6_reframe got=%b/%h/%h exp=1/%h/7777", m_axis_tvalid, m_axis_tdata, m_axis_tuser, full_beat(7)); end
        @(posedge clk_i); #1;
        total++; if (stat_rx_frames !== 32'd10 || stat_rx_bytes !== 32'd229) begin
            bad++; $display("FAIL t6_stats got=%0d/%0d exp=10/229", stat_rx_frames, stat_rx_bytes); end
        drop_on_midreset = 1'b0;
    endtask

    task automatic test_reset_midframe;
        push_seg(pat(8, 0), 8'hFF, 16'h8888, 1'b1, 1'b0);
        push_seg(pat(8, 1), 8'hFF, 16'h8888, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1; bridge_enable = 1'b0;
        @(posedge clk_i); #1;
        total++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser} !== 50'd0 || m_axis_tdata !== 256'd0) begin
            bad++; $display("FAIL t7_axis got=%b/%b/%h/%h exp=0", m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser); end
        total++; if ({stat_rx_frames, stat_rx_bytes, stat_rx_stall_cycles, stat_rx_fifo_level} !== 112'd0) begin
            bad++; $display("FAIL t7_stats got=%h exp=0", {stat_rx_frames, stat_rx_bytes, stat_rx_stall_cycles, stat_rx_fifo_level}); end
        total++; if ({cl_rx_ready, ev_err_seq, ev_err_keep_illegal, ev_err_midreset_drop} !== 4'b0000) begin
            bad++; $display("FAIL t7_misc got=%b exp=0000", {cl_rx_ready, ev_err_seq, ev_err_keep_illegal, ev_err_midreset_drop}); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_beat();
        test_partial_beat();
        test_back_to_back();
        test_strict_seq();
        test_strict_keep();
        test_midreset_drop();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_bridge_ip_rx.md
Name: axi_bridge_ip_rx

Overview:
Egress path of the IP bridge: accepts IF_W-wide Client-IF segments from the Protocol layer and packs them into DATA_W-wide AXI-Stream beats toward the IP. A frame is delimited by sop/eop. Per-frame tuser is captured at SOP. Complete beats are buffered in a small FWFT egress FIFO, and CSR-visible telemetry and error pulses are provided.

Parameters:
DATA_W, 256, AXI-Stream data width toward the IP; multiple of IF_W.
IF_W, 64, Client-IF segment width; multiple of 8.
TUSER_W, 16, metadata width (VC, DST, etc.).
FIFO_DEPTH, 4, egress FIFO depth in beats; must be ≥2.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
cl_rx_data  in  IF_W  segment data, byte 0 in LSBs
cl_rx_keep  in  IF_W/8  segment byte enables
cl_rx_user  in  TUSER_W  metadata, sampled only on SOP
cl_rx_valid  in  1  segment valid
cl_rx_sop  in  1  first segment of frame
cl_rx_eop  in  1  last segment of frame
cl_rx_ready  out  1  segment accept
m_axis_tdata  out  DATA_W  beat data
m_axis_tkeep  out  DATA_W/8  beat byte enables
m_axis_tuser  out  TUSER_W  frame metadata
m_axis_tvalid  out  1  beat valid
m_axis_tlast  out  1  last beat of frame
m_axis_tready  in  1  IP accept
bridge_enable  in  1  CSR: enables ingest of segments
strict_seq_en  in  1  CSR: enforce sop/eop framing
strict_keep_en  in  1  CSR: check segment keep legality
drop_on_midreset  in  1  CSR: flush on bridge_enable fall
stat_rx_frames  out  32  tlast beats delivered to the IP
stat_rx_bytes  out  32  bytes packed
stat_rx_fifo_level  out  16  egress FIFO occupancy, zero-extended
stat_rx_stall_cycles  out  32  cycles with m_axis_tvalid && !m_axis_tready
ev_err_seq  out  1  1-cycle pulse: framing violation
ev_err_keep_illegal  out  1  1-cycle pulse: illegal segment keep
ev_err_midreset_drop  out  1  1-cycle pulse: mid-frame flush

Behaviour:
- SEGS_PER_BEAT = DATA_W/IF_W; BYTES_PER_SEG = IF_W/8.
- Reset (rst_i=1 at a clock edge): all outputs 0. The packer, the FIFO, the framing state (IDLE) and all counters are cleared.
- Segment accept: seg_fire = cl_rx_valid && cl_rx_ready.
- cl_rx_ready = bridge_enable && (fifo_level < FIFO_DEPTH), combinational.
  - A pop in the same cycle does not raise ready; there is no pass-through.
- Packer state: seg_idx (0..SEGS_PER_BEAT-1), acc_data, acc_keep, frame_user.
- Each accepted segment is written at byte slot seg_idx*BYTES_PER_SEG. cl_rx_keep is copied verbatim into acc_keep at the same slot. Bytes are never compacted.
- Beat close: the beat closes on the accepted segment if seg_idx==SEGS_PER_BEAT-1 or cl_rx_eop=1.
  - At that edge, {acc+segment, keep, frame_user, tlast=eop} is pushed to the FIFO.
  - seg_idx returns to 0 and acc_keep clears.
  - Otherwise seg_idx increments.
- Latency: the closing segment accepted at edge N gives m_axis_tvalid=1 after edge N when the FIFO was empty (FWFT).
- Output: m_axis_tvalid = !fifo_empty. The FIFO head drives tdata, tkeep, tuser and tlast. It pops on m_axis_tvalid && m_axis_tready.
- Output is held stable while stalled.
- Framing FSM states: IDLE and IN_PKT.
  - IDLE, sop=1: capture cl_rx_user into frame_user and pack. If eop=1 as well, stay IDLE; otherwise go to IN_PKT.
  - IDLE, sop=0, strict_seq_en=1: consume the segment and drop it (no pack, no byte count); pulse ev_err_seq.
  - IDLE, sop=0, strict_seq_en=0: treat as an implicit SOP (capture user).
  - IN_PKT, sop=1: pulse ev_err_seq whenever strict_seq_en=1. The sop is ignored and the segment continues the current frame; frame_user is not recaptured.
  - IN_PKT, eop=1: go to IDLE.
- Keep check (strict_keep_en=1): pulse ev_err_keep_illegal if either condition holds. The segment is still packed.
  - A non-eop segment has keep != all-ones.
  - An eop segment has keep that is not LSB-contiguous (1..10..0) or is all-zero.
- stat_rx_bytes += popcount(cl_rx_keep) per packed segment.
- stat_rx_frames +1 per output handshake with tlast=1.
- All 32-bit counters wrap modulo 2^32.
- stat_rx_fifo_level is registered, one cycle behind.
- bridge_enable=0: no new segments are accepted. The FIFO keeps draining to the IP, and packer and FSM state are held.
- Mid-frame drop: applies when drop_on_midreset=1 and bridge_enable falls (registered 1→0 detect) while IN_PKT, seg_idx≠0, or the FIFO is non-empty.
  - Next edge: clear packer, FSM (to IDLE) and FIFO; m_axis_tvalid drops to 0.
  - Pulse ev_err_midreset_drop for one cycle. Counters are not cleared.
- Event pulses are registered, asserted the cycle after the causing edge, and last exactly one cycle.

Test Plan:
- 4 full segments (keep=0xFF), sop on the 1st and eop on the 4th, tready=1 → one beat with tkeep=all-ones and tlast=1 one cycle after the 4th accept; stat_rx_frames=1, stat_rx_bytes=32.
- 6-segment frame, last segment keep=0x0F → beat0 tkeep=all-ones, tlast=0; beat1 tkeep=0x00000FFF, tlast=1; both beats carry the SOP tuser (e.g. 0xA5A5) even though cl_rx_user changes mid-frame.
- tready=0 with back-to-back frames → FIFO fills to 4 and cl_rx_ready=0; stat_rx_stall_cycles counts each stalled cycle; on release, beats drain in order with no loss or duplication.
- strict_seq_en=1: segment without sop in IDLE → ev_err_seq pulse, no output beat, stat_rx_bytes unchanged; a second sop inside a frame → ev_err_seq pulse and the frame continues intact.
- strict_keep_en=1: a non-eop segment with keep=0x7F → ev_err_keep_illegal pulse; the beat tkeep shows the hole at that slot.
- drop_on_midreset=1: deassert bridge_enable after 2 segments of a frame → ev_err_midreset_drop pulse, FIFO cleared, m_axis_tvalid=0. On re-enable, a new sop frame packs from slot 0. Assert rst_i mid-frame → all outputs 0 the next cycle.
